// File: rtl/timer_counter.sv
// General-purpose timer/counter: free-run, periodic, one-shot and down-count modes with sticky overflow/compare flags.
// Define TIMER_CAPTURE_EN to add the input-capture register (cap_in/cap_val/cap_flag/clr_cap).
module timer_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_pulse,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] cmp,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    input  logic             clr_cmp,
    input  logic             ovf_ie,
    input  logic             cmp_ie,
    output logic [WIDTH-1:0] count,
    output logic             ovf_flag,
    output logic             cmp_flag,
    output logic             irq,
    output logic             running
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic             cap_in,
    input  logic             clr_cap,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_flag
`endif
);

    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_PERIOD = 2'b01;
    localparam logic [1:0] MODE_ONCE   = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    logic             tick;
    logic             tick_eff;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_evt;
    logic             term_evt;
    logic             ovf_evt;
    logic             cmp_evt;
    logic             once_done;

    // Next count for a tick; a simultaneous load discards the tick and its events.
    always_comb begin
        count_nxt = count;
        wrap_evt  = 1'b0;
        term_evt  = 1'b0;
        tick      = clk_pulse && (state == RUN);
        tick_eff  = tick && !load;
        unique case (mode)
            MODE_FREE: begin
                count_nxt = count + CNT_ONE;
                wrap_evt  = (count == CNT_MAX);
            end
            MODE_PERIOD: begin
                if (count == period) begin
                    count_nxt = '0;
                    wrap_evt  = 1'b1;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            MODE_ONCE: begin
                if (count == period) begin
                    count_nxt = period;
                    wrap_evt  = 1'b1;
                    term_evt  = 1'b1;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
            end
            MODE_DOWN: begin
                if (count == '0) begin
                    count_nxt = period;
                    wrap_evt  = 1'b1;
                end else begin
                    count_nxt = count - CNT_ONE;
                end
            end
            default: count_nxt = count;
        endcase
        ovf_evt   = tick_eff && wrap_evt;
        cmp_evt   = tick_eff && (count_nxt == cmp);
        once_done = tick_eff && term_evt;
    end

    // Counter, flags and run-state FSM; a flag set wins over its clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            running  <= 1'b0;
            count    <= '0;
            ovf_flag <= 1'b0;
            cmp_flag <= 1'b0;
        end else begin
            if (load) begin
                count <= load_val;
            end else if (tick) begin
                count <= count_nxt;
            end

            if (ovf_evt) begin
                ovf_flag <= 1'b1;
            end else if (clr_ovf) begin
                ovf_flag <= 1'b0;
            end

            if (cmp_evt) begin
                cmp_flag <= 1'b1;
            end else if (clr_cmp) begin
                cmp_flag <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (once_done) begin
                        state   <= DONE;
                        running <= 1'b0;
                    end
                end
                DONE: begin
                    if (!en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIMER_CAPTURE_EN
    // Snapshot of the current count on a capture strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_val  <= '0;
            cap_flag <= 1'b0;
        end else if (cap_in) begin
            cap_val  <= count;
            cap_flag <= 1'b1;
        end else if (clr_cap) begin
            cap_flag <= 1'b0;
        end
    end

    assign irq = (ovf_flag & ovf_ie) | (cmp_flag & cmp_ie) | cap_flag;
`else
    assign irq = (ovf_flag & ovf_ie) | (cmp_flag & cmp_ie);
`endif

endmodule
